commit_trace_unit: RTL and testbench

COMMIT_TRACE_UNIT -- requirements
Module: commit_trace_unit

---
 rtl/commit_trace_unit_pkg.sv | 38 +++
 rtl/commit_trace_unit_if.sv | 37 +++
 rtl/commit_trace_unit_fifo.sv | 59 +++++
 rtl/commit_trace_unit.sv | 154 +++++++++++++++
 tb/tb_commit_trace_unit.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/commit_trace_unit_pkg.sv
// Shared definitions for the commit trace unit.
//   - serializer state encoding
//   - commit record layout: {PC[31:0], RegDst[4:0], Data[31:0]}, PC in the MSBs
//   - word-index constants and a helper that extracts one 32-bit trace word
package commit_trace_unit_pkg;

    localparam int PC_W     = 32;
    localparam int DST_W    = 5;
    localparam int DATA_W   = 32;
    localparam int REC_W    = PC_W + DST_W + DATA_W;

    localparam int DATA_LSB = 0;
    localparam int DST_LSB  = DATA_W;
    localparam int PC_LSB   = DATA_W + DST_W;

    localparam logic [1:0] WORD_PC   = 2'd0;
    localparam logic [1:0] WORD_DST  = 2'd1;
    localparam logic [1:0] WORD_DATA = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_W0   = 2'd1,
        ST_W1   = 2'd2,
        ST_W2   = 2'd3
    } ser_state_e;

    function automatic logic [31:0] rec_word(input logic [REC_W-1:0] rec,
                                             input logic [1:0]       idx);
        logic [31:0] word;
        case (idx)
            WORD_PC:  word = rec[PC_LSB +: PC_W];
            WORD_DST: word = {{(32-DST_W){1'b0}}, rec[DST_LSB +: DST_W]};
            default:  word = rec[DATA_LSB +: DATA_W];
        endcase
        return word;
    endfunction

endpackage

// File: rtl/commit_trace_unit_if.sv
// Signal bundle between the writeback/trace consumer side and the trace unit.
//   master : drives commit inputs, TraceReady and ClrOverflow; observes trace outputs
//   slave  : the trace unit itself
interface commit_trace_if #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
);
    logic                     TraceEn;
    logic                     WbValid;
    logic                     WbRegWrite;
    logic [4:0]               WbRegDst;
    logic [31:0]              WriteData;
    logic [31:0]              PCValue;
    logic                     ClrOverflow;
    logic                     TraceReady;
    logic                     TraceValid;
    logic [31:0]              TraceData;
    logic                     TraceFirst;
    logic                     TraceLast;
    logic                     Overflow;
    logic [CNT_W-1:0]         DropCount;
    logic [$clog2(DEPTH):0]   Count;

    modport master (
        output TraceEn, WbValid, WbRegWrite, WbRegDst, WriteData, PCValue,
               ClrOverflow, TraceReady,
        input  TraceValid, TraceData, TraceFirst, TraceLast, Overflow,
               DropCount, Count
    );

    modport slave (
        input  TraceEn, WbValid, WbRegWrite, WbRegDst, WriteData, PCValue,
               ClrOverflow, TraceReady,
        output TraceValid, TraceData, TraceFirst, TraceLast, Overflow,
               DropCount, Count
    );
endinterface

// File: rtl/commit_trace_unit_fifo.sv
// trace_fifo: synchronous FIFO of commit records.
// Ports:
//   clk, rst_n      clock, async active-low reset (pointers and count only)
//   i_push, i_pop   write / read strobes; both may be active on the same edge
//   i_wdata         record to write
//   o_rdata         head record (valid while o_count != 0)
//   o_count         records held, 0..DEPTH
// The caller never pushes when full without a pop, nor pops when empty.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 69
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic [WIDTH-1:0]        i_wdata,
    output logic [WIDTH-1:0]        o_rdata,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/commit_trace_unit.sv
// commit_trace_unit: captures register-file writebacks into a record FIFO and
// serializes each record as three 32-bit words (PC, RegDst, Data) over a
// valid/ready stream. Drops on a full FIFO are flagged and counted.
// Ports:
//   Clk   system clock
//   Rst   async active-low reset; release is aligned to Clk internally
//   bus   commit_trace_if.slave (commit inputs, trace stream, status)
//
// state   | meaning
// IDLE    | nothing presented, FIFO empty at last look
// W0      | presenting head.PC (TraceFirst)
// W1      | presenting head.RegDst
// W2      | presenting head.Data (TraceLast); handshake pops the record
module commit_trace_unit
    import commit_trace_unit_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic            Clk,
    input  logic            Rst,
    commit_trace_if.slave   bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              r_run;
    ser_state_e        r_state;
    ser_state_e        w_next;
    logic [CW-1:0]     w_count;
    logic [REC_W-1:0]  w_head;
    logic [REC_W-1:0]  w_wr_rec;
    logic              w_qual;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              r_ovf;
    logic [CNT_W-1:0]  r_drop_cnt;
    logic              w_valid;
    logic              w_first;
    logic              w_last;
    logic [31:0]       w_data;

    // Capture is held off for the first edge after reset release so the
    // release itself never races a capture.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    assign w_qual   = r_run & bus.TraceEn & bus.WbValid & bus.WbRegWrite &
                      (bus.WbRegDst != 5'd0);
    assign w_full   = (w_count == CW'(DEPTH));
    assign w_pop    = (r_state == ST_W2) & bus.TraceReady;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign w_push   = w_qual & (~w_full | w_pop);
    assign w_drop   = w_qual & ~w_push;
    assign w_wr_rec = {bus.PCValue, bus.WbRegDst, bus.WriteData};

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk     (Clk),
        .rst_n   (Rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wr_rec),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_valid = 1'b0;
        w_first = 1'b0;
        w_last  = 1'b0;
        w_data  = 32'd0;
        case (r_state)
            ST_IDLE: begin
                if (w_count != '0) begin
                    w_next = ST_W0;
                end
            end
            ST_W0: begin
                w_valid = 1'b1;
                w_first = 1'b1;
                w_data  = rec_word(w_head, WORD_PC);
                if (bus.TraceReady) begin
                    w_next = ST_W1;
                end
            end
            ST_W1: begin
                w_valid = 1'b1;
                w_data  = rec_word(w_head, WORD_DST);
                if (bus.TraceReady) begin
                    w_next = ST_W2;
                end
            end
            ST_W2: begin
                w_valid = 1'b1;
                w_last  = 1'b1;
                w_data  = rec_word(w_head, WORD_DATA);
                if (bus.TraceReady) begin
                    // Occupancy after this pop, including a same-edge push.
                    if ((w_count > CW'(1)) || w_push) begin
                        w_next = ST_W0;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // A drop coinciding with a clear restarts the tally at one.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (bus.ClrOverflow) begin
                r_drop_cnt <= CNT_W'(1);
            end else if (r_drop_cnt != '1) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end else if (bus.ClrOverflow) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    assign bus.TraceValid = w_valid;
    assign bus.TraceData  = w_data;
    assign bus.TraceFirst = w_first;
    assign bus.TraceLast  = w_last;
    assign bus.Overflow   = r_ovf;
    assign bus.DropCount  = r_drop_cnt;
    assign bus.Count      = w_count;

endmodule

// File: tb/tb_commit_trace_unit.sv
module tb_commit_trace_unit;

    localparam int DEPTH = 8;
    localparam int CNT_W = 8;
    localparam int MAXD  = (1 << CNT_W) - 1;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  dst;
        logic [31:0] data;
    } rec_t;

    logic Clk;
    logic Rst;

    commit_trace_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    commit_trace_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a queue of records, the index of the word currently on
    // offer (-1 = none), sticky overflow and a saturating drop tally.
    rec_t m_q[$];
    int   m_widx;
    bit   m_ovf;
    int   m_drops;
    bit   m_run;

    task automatic chk_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_word();
        if (m_widx == 0) return m_q[0].pc;
        if (m_widx == 1) return {27'd0, m_q[0].dst};
        if (m_widx == 2) return m_q[0].data;
        return 32'd0;
    endfunction

    task automatic check_outputs();
        chk_eq("valid", 32'(bus.TraceValid), 32'(m_widx >= 0));
        chk_eq("data",  bus.TraceData, exp_word());
        chk_eq("first", 32'(bus.TraceFirst), 32'(m_widx == 0));
        chk_eq("last",  32'(bus.TraceLast), 32'(m_widx == 2));
        chk_eq("count", 32'(bus.Count), 32'(m_q.size()));
        chk_eq("ovf",   32'(bus.Overflow), 32'(m_ovf));
        chk_eq("drops", 32'(bus.DropCount), 32'(m_drops));
    endtask

    // Called at a falling edge: check, drive, advance model, wait next falling edge.
    task automatic step(input logic en, input logic valid, input logic rw,
                        input logic [4:0] dst, input logic [31:0] pc,
                        input logic [31:0] data, input logic clr,
                        input logic ready);
        bit   qual;
        bit   pop;
        bit   push;
        bit   drop;
        int   sz;
        int   nw;
        rec_t r;
        check_outputs();
        bus.TraceEn     = en;
        bus.WbValid     = valid;
        bus.WbRegWrite  = rw;
        bus.WbRegDst    = dst;
        bus.PCValue     = pc;
        bus.WriteData   = data;
        bus.ClrOverflow = clr;
        bus.TraceReady  = ready;

        sz   = m_q.size();
        qual = m_run && en && valid && rw && (dst != 5'd0);
        pop  = (m_widx == 2) && ready;
        push = qual && ((sz < DEPTH) || pop);
        drop = qual && !push;
        if (m_widx < 0)       nw = (sz != 0) ? 0 : -1;
        else if (!ready)      nw = m_widx;
        else if (m_widx < 2)  nw = m_widx + 1;
        else                  nw = ((sz - 1 + int'(push)) != 0) ? 0 : -1;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            r.pc = pc; r.dst = dst; r.data = data;
            m_q.push_back(r);
        end
        m_widx = nw;
        if (drop) begin
            m_ovf   = 1'b1;
            m_drops = clr ? 1 : ((m_drops == MAXD) ? MAXD : m_drops + 1);
        end else if (clr) begin
            m_ovf   = 1'b0;
            m_drops = 0;
        end
        m_run = 1'b1;
        @(negedge Clk);
    endtask

    task automatic idle(input int n, input logic ready);
        for (int i = 0; i < n; i++) step(1, 0, 0, 5'd0, 32'd0, 32'd0, 0, ready);
    endtask

    task automatic commit(input logic [4:0] dst, input logic [31:0] pc,
                          input logic [31:0] data, input logic ready);
        step(1, 1, 1, dst, pc, data, 0, ready);
    endtask

    // Asserts reset mid low-phase, checks async clear, releases at a falling edge.
    task automatic do_reset();
        @(negedge Clk);
        #2;
        Rst = 1'b0;
        #1;
        chk_eq("rst_valid", 32'(bus.TraceValid), 32'd0);
        chk_eq("rst_data",  bus.TraceData, 32'd0);
        chk_eq("rst_first", 32'(bus.TraceFirst), 32'd0);
        chk_eq("rst_last",  32'(bus.TraceLast), 32'd0);
        chk_eq("rst_ovf",   32'(bus.Overflow), 32'd0);
        chk_eq("rst_drops", 32'(bus.DropCount), 32'd0);
        chk_eq("rst_count", 32'(bus.Count), 32'd0);
        m_q.delete();
        m_widx  = -1;
        m_ovf   = 1'b0;
        m_drops = 0;
        m_run   = 1'b0;
        bus.WbValid     = 1'b0;
        bus.ClrOverflow = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    task automatic rand_phase(input int n, input int ready_pct, input int clr_pct);
        logic [4:0] dst;
        for (int i = 0; i < n; i++) begin
            dst = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            step(logic'($urandom_range(0, 9) != 0),
                 logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 4) != 0),
                 dst, $urandom, $urandom,
                 logic'($urandom_range(0, 99) < clr_pct),
                 logic'($urandom_range(0, 99) < ready_pct));
        end
    endtask

    initial begin
        Rst             = 1'b0;
        bus.TraceEn     = 1'b0;
        bus.WbValid     = 1'b0;
        bus.WbRegWrite  = 1'b0;
        bus.WbRegDst    = 5'd0;
        bus.PCValue     = 32'd0;
        bus.WriteData   = 32'd0;
        bus.ClrOverflow = 1'b0;
        bus.TraceReady  = 1'b0;
        m_widx = -1;

        do_reset();
        // First edge after release must not capture.
        commit(5'd3, 32'hdead, 32'hbeef, 1);
        idle(2, 1);
        chk_eq("sync_no_capture", 32'(bus.Count), 32'd0);

        // Single commit.
        commit(5'd17, 32'h14, 32'h12c, 1);
        idle(6, 1);

        // Filtering: $zero destination and non-writing store.
        commit(5'd0, 32'h20, 32'h5, 1);
        step(1, 1, 0, 5'd9, 32'h24, 32'h6, 0, 1);
        step(0, 1, 1, 5'd9, 32'h28, 32'h7, 0, 1);
        idle(3, 1);

        // Backpressure in W1.
        commit(5'd17, 32'h14, 32'h12c, 1);
        idle(2, 1);
        idle(5, 0);
        idle(4, 1);

        // Streaming three records.
        commit(5'd1, 32'h100, 32'h11, 1);
        commit(5'd2, 32'h104, 32'h22, 1);
        commit(5'd3, 32'h108, 32'h33, 1);
        idle(12, 1);

        // Overflow: ten commits into a stalled FIFO.
        do_reset();
        idle(1, 0);
        for (int i = 0; i < 10; i++)
            commit(5'(i + 1), 32'h1000 + 32'(4 * i), 32'hA000 + 32'(i), 0);
        chk_eq("ovf_count", 32'(bus.Count), 32'd8);
        chk_eq("ovf_flag",  32'(bus.Overflow), 32'd1);
        chk_eq("ovf_drops", 32'(bus.DropCount), 32'd2);
        step(1, 0, 0, 5'd0, 32'd0, 32'd0, 1, 0);
        chk_eq("clr_flag",  32'(bus.Overflow), 32'd0);
        chk_eq("clr_drops", 32'(bus.DropCount), 32'd0);
        idle(30, 1);

        // Full FIFO accepting on the edge its head leaves, and drop-vs-clear.
        idle(1, 0);
        for (int i = 0; i < 8; i++) commit(5'd4, 32'(i), 32'(i), 0);
        idle(2, 1);
        commit(5'd5, 32'h55, 32'h55, 1);
        commit(5'd6, 32'h66, 32'h66, 0);
        step(1, 1, 1, 5'd7, 32'h77, 32'h77, 1, 0);
        idle(40, 1);

        rand_phase(1500, 75, 5);

        // Drop tally saturation.
        step(1, 0, 0, 5'd0, 32'd0, 32'd0, 1, 0);
        for (int i = 0; i < 300; i++) commit(5'd8, $urandom, $urandom, 0);
        chk_eq("sat_drops", 32'(bus.DropCount), 32'(MAXD));
        idle(40, 1);

        // Reset while in W1 with two records queued.
        commit(5'd10, 32'h200, 32'h1, 0);
        commit(5'd11, 32'h204, 32'h2, 0);
        idle(1, 1);
        chk_eq("pre_rst_w1", bus.TraceData, 32'd10);
        do_reset();
        idle(6, 1);

        rand_phase(1500, 60, 3);
        rand_phase(500, 95, 0);
        idle(30, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
